// File: rtl/conv_window_reader_pkg.sv
// Shared sizing helpers, default frame geometry and the reader FSM state encoding.
package conv_window_reader_pkg;

  // Bit count of value; identical to the image RAM's address sizing.
  function automatic int clogb2(input int value);
    int v;
    int n;
    v = value;
    n = 0;
    while (v > 0) begin
      n++;
      v = v >> 1;
    end
    return n;
  endfunction

  function automatic int out_dim(input int img, input int k, input int stride);
    return (img - k) / stride + 1;
  endfunction

  localparam int DEF_IMG_W  = 28;
  localparam int DEF_IMG_H  = 28;
  localparam int DEF_K      = 3;
  localparam int DEF_STRIDE = 1;
  localparam int OUT_W      = out_dim(DEF_IMG_W, DEF_K, DEF_STRIDE);
  localparam int OUT_H      = out_dim(DEF_IMG_H, DEF_K, DEF_STRIDE);
  localparam int WIN_WORDS  = DEF_K * DEF_K;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/conv_window_addr_gen.sv
// Window walker: nested kc/kr/oc/orow counters, RAM address arithmetic and
// the per-pixel position flags for the pixel currently addressed.
module conv_window_addr_gen
  import conv_window_reader_pkg::*;
#(
  parameter int IMG_W    = DEF_IMG_W,
  parameter int IMG_H    = DEF_IMG_H,
  parameter int K        = DEF_K,
  parameter int STRIDE   = DEF_STRIDE,
  parameter int ADR_SIZE = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                step,
  output logic [ADR_SIZE-1:0] adr,
  output logic                first,
  output logic                last,
  output logic                frame_last
);

  localparam int OUT_COLS = out_dim(IMG_W, K, STRIDE);
  localparam int OUT_ROWS = out_dim(IMG_H, K, STRIDE);
  localparam int KW       = clogb2(K);
  localparam int CW       = clogb2(OUT_COLS);
  localparam int RW       = clogb2(OUT_ROWS);
  localparam int AW1      = ADR_SIZE + 1;

  logic [KW-1:0]  kc, kr;
  logic [CW-1:0]  oc;
  logic [RW-1:0]  orow;
  logic           kc_end, kr_end, oc_end, orow_end;
  logic [AW1-1:0] row, col;

  assign kc_end   = (kc == KW'(K - 1));
  assign kr_end   = (kr == KW'(K - 1));
  assign oc_end   = (oc == CW'(OUT_COLS - 1));
  assign orow_end = (orow == RW'(OUT_ROWS - 1));

  // kc is the fastest counter; each wrap carries into the next one out.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      kc   <= '0;
      kr   <= '0;
      oc   <= '0;
      orow <= '0;
    end else if (step) begin
      if (!kc_end) begin
        kc <= kc + 1'b1;
      end else begin
        kc <= '0;
        if (!kr_end) begin
          kr <= kr + 1'b1;
        end else begin
          kr <= '0;
          if (!oc_end) begin
            oc <= oc + 1'b1;
          end else begin
            oc <= '0;
            orow <= orow_end ? '0 : orow + 1'b1;
          end
        end
      end
    end
  end

  // One extra bit of headroom keeps the products from wrapping before truncation.
  always_comb begin
    row = AW1'(orow) * AW1'(STRIDE) + AW1'(kr);
    col = AW1'(oc) * AW1'(STRIDE) + AW1'(kc);
  end

  assign adr        = ADR_SIZE'(row * AW1'(IMG_W) + col);
  assign first      = (kc == '0) && (kr == '0);
  assign last       = kc_end && kr_end;
  assign frame_last = last && oc_end && orow_end;

endmodule

// File: rtl/conv_window_reader.sv
// Streams every KxK window of a stored frame from the image RAM to the conv MAC
// stage over valid/ready; the RAM read is combinational so data lands in the capture cycle.
module conv_window_reader
  import conv_window_reader_pkg::*;
#(
  parameter  int WORD_SIZE   = 8,
  parameter  int IMG_W       = DEF_IMG_W,
  parameter  int IMG_H       = DEF_IMG_H,
  parameter  int K           = DEF_K,
  parameter  int STRIDE      = DEF_STRIDE,
  parameter  int LENGTH_SIZE = 784,
  localparam int ADR_SIZE    = clogb2(LENGTH_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 ram_rd,
  output logic                 ram_wr,
  output logic [ADR_SIZE-1:0]  ram_adr,
  input  logic [WORD_SIZE-1:0] ram_data,
  output logic [WORD_SIZE-1:0] win_data,
  output logic                 win_valid,
  input  logic                 win_ready,
  output logic                 win_first,
  output logic                 win_last,
  output logic                 frame_last
);

  state_t              state, state_nx;
  logic                cap;
  logic [ADR_SIZE-1:0] gen_adr;
  logic                gen_first, gen_last, gen_frame_last;

  // A new pixel is fetched whenever the output slot is empty or being drained.
  assign cap = (state == RUN) && (!win_valid || win_ready);

  conv_window_addr_gen #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .K       (K),
    .STRIDE  (STRIDE),
    .ADR_SIZE(ADR_SIZE)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .clear     ((state == IDLE) && start),
    .step      (cap),
    .adr       (gen_adr),
    .first     (gen_first),
    .last      (gen_last),
    .frame_last(gen_frame_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (cap && gen_frame_last) state_nx = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (win_valid && win_ready) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign ram_rd  = cap;
  assign ram_wr  = 1'b0;
  assign ram_adr = cap ? gen_adr : '0;

  // Pixel and its position flags are registered together so they stay aligned under stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_data   <= '0;
      win_valid  <= 1'b0;
      win_first  <= 1'b0;
      win_last   <= 1'b0;
      frame_last <= 1'b0;
    end else if (cap) begin
      win_data   <= ram_data;
      win_valid  <= 1'b1;
      win_first  <= gen_first;
      win_last   <= gen_last;
      frame_last <= gen_frame_last;
    end else if (win_valid && win_ready) begin
      win_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_reader.sv
// Directed bench for conv_window_reader: a 28x28/K3/S1 instance and a 6x6/K3/S2 instance,
// each fed by a combinational RAM model holding mem[a] = a[7:0].
module tb_conv_window_reader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // default-geometry instance
  logic       start_a, busy_a, done_a, ram_rd_a, ram_wr_a;
  logic [9:0] ram_adr_a;
  logic [7:0] ram_data_a, win_data_a;
  logic       win_valid_a, win_ready_a, win_first_a, win_last_a, frame_last_a;
  logic [7:0] mem_a [0:783];

  // 6x6, stride-2 instance (RAM depth 36 -> 6 address bits)
  logic       start_b, busy_b, done_b, ram_rd_b, ram_wr_b;
  logic [5:0] ram_adr_b;
  logic [7:0] ram_data_b, win_data_b;
  logic       win_valid_b, win_ready_b, win_first_b, win_last_b, frame_last_b;
  logic [7:0] mem_b [0:35];

  assign ram_data_a = ram_rd_a ? mem_a[ram_adr_a] : 'z;
  assign ram_data_b = ram_rd_b ? mem_b[ram_adr_b] : 'z;

  conv_window_reader dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .ram_rd(ram_rd_a), .ram_wr(ram_wr_a), .ram_adr(ram_adr_a), .ram_data(ram_data_a),
    .win_data(win_data_a), .win_valid(win_valid_a), .win_ready(win_ready_a),
    .win_first(win_first_a), .win_last(win_last_a), .frame_last(frame_last_a)
  );

  conv_window_reader #(
    .WORD_SIZE(8), .IMG_W(6), .IMG_H(6), .K(3), .STRIDE(2), .LENGTH_SIZE(36)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .ram_rd(ram_rd_b), .ram_wr(ram_wr_b), .ram_adr(ram_adr_b), .ram_data(ram_data_b),
    .win_data(win_data_b), .win_valid(win_valid_b), .win_ready(win_ready_b),
    .win_first(win_first_b), .win_last(win_last_b), .frame_last(frame_last_b)
  );

  int total = 0;
  int bad   = 0;

  // statistics gathered by run_frame for the default instance
  int         nwords, data_errs, flag_errs, stall_errs, stall_cycles, done_cnt, busy_errs;
  int         wr_errs, fl_count, first_valid_cyc, last_acc_cyc, done_cyc, first_bad;
  logic [7:0] last_data;
  logic [7:0] cap_data  [0:15];
  logic       cap_first [0:15];
  logic       cap_last  [0:15];

  // Reference address for the n-th streamed word, derived by division rather than counting.
  function automatic int exp_adr(input int n, input int img_w, input int k,
                                 input int stride, input int out_w);
    int e, win;
    e   = n % (k * k);
    win = n / (k * k);
    return ((win / out_w) * stride + e / k) * img_w + (win % out_w) * stride + e % k;
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Starts a frame on the default instance and watches it every cycle until done
  // (or stop_at words have been accepted, or the cycle budget runs out).
  task automatic run_frame(input bit rand_ready, input bit inject_start, input int stop_at);
    int         cyc, ea;
    logic       held_valid;
    logic [7:0] held_data;
    logic [2:0] held_flags;
    nwords = 0; data_errs = 0; flag_errs = 0; stall_errs = 0; stall_cycles = 0;
    done_cnt = 0; busy_errs = 0; wr_errs = 0; fl_count = 0;
    first_valid_cyc = -1; last_acc_cyc = -1; done_cyc = -1; first_bad = -1;
    last_data = '0; held_valid = 1'b0; held_data = '0; held_flags = '0;
    @(negedge clk);
    start_a = 1'b1; win_ready_a = 1'b1; cyc = 0;
    while (cyc < 40000) begin
      #1;
      if (held_valid && (!win_valid_a || win_data_a !== held_data ||
          {win_first_a, win_last_a, frame_last_a} !== held_flags))
        stall_errs++;
      if (win_valid_a && !win_ready_a) begin
        stall_cycles++;
        if (ram_rd_a !== 1'b0) stall_errs++;
      end
      held_valid = win_valid_a && !win_ready_a;
      held_data  = win_data_a;
      held_flags = {win_first_a, win_last_a, frame_last_a};
      if (ram_wr_a !== 1'b0) wr_errs++;
      if (win_valid_a && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (cyc >= 1 && done_cyc < 0 && !done_a && busy_a !== 1'b1) busy_errs++;
      if (done_cyc >= 0 && busy_a !== 1'b0) busy_errs++;
      if (win_valid_a && win_ready_a) begin
        ea = exp_adr(nwords, 28, 3, 1, 26);
        if (win_data_a !== 8'(ea)) begin
          data_errs++;
          if (first_bad < 0) first_bad = nwords;
        end
        if (win_first_a !== (nwords % 9 == 0) || win_last_a !== (nwords % 9 == 8) ||
            frame_last_a !== (nwords == 6083))
          flag_errs++;
        if (frame_last_a) fl_count++;
        if (nwords < 16) begin
          cap_data[nwords]  = win_data_a;
          cap_first[nwords] = win_first_a;
          cap_last[nwords]  = win_last_a;
        end
        last_data    = win_data_a;
        last_acc_cyc = cyc;
        nwords++;
      end
      if (done_a) begin
        done_cnt++;
        done_cyc = cyc;
        if (busy_a !== 1'b0) busy_errs++;
      end
      if (stop_at > 0 && nwords == stop_at) break;
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      @(negedge clk);
      cyc++;
      start_a     = inject_start && (busy_a || done_a) && ((cyc % 500) == 0 || done_a);
      win_ready_a = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    start_a = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({busy_a, done_a, win_valid_a, ram_rd_a, ram_wr_a, win_first_a, win_last_a, frame_last_a} !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_ctrl_a: got %b, want 00000000",
               {busy_a, done_a, win_valid_a, ram_rd_a, ram_wr_a, win_first_a, win_last_a, frame_last_a});
    end
    total++;
    if (ram_adr_a !== 10'd0) begin bad++; $display("[TB] FAIL reset_adr_a: got %0d, want 0", ram_adr_a); end
    total++;
    if (win_data_a !== 8'd0) begin bad++; $display("[TB] FAIL reset_data_a: got %0d, want 0", win_data_a); end
    total++;
    if ({busy_b, done_b, win_valid_b, ram_rd_b, ram_wr_b, frame_last_b} !== 6'h00) begin
      bad++;
      $display("[TB] FAIL reset_ctrl_b: got %b, want 000000",
               {busy_b, done_b, win_valid_b, ram_rd_b, ram_wr_b, frame_last_b});
    end
    rst = 1'b0;
  endtask

  task automatic test_first_window();
    logic [7:0] want [0:9];
    want = '{8'd0, 8'd1, 8'd2, 8'd28, 8'd29, 8'd30, 8'd56, 8'd57, 8'd58, 8'd1};
    run_frame(1'b0, 1'b0, 12);
    for (int i = 0; i < 10; i++) begin
      total++;
      if (cap_data[i] !== want[i]) begin
        bad++;
        $display("[TB] FAIL first_win_word%0d: got %0d, want %0d", i, cap_data[i], want[i]);
      end
    end
    total++;
    if (cap_first[0] !== 1'b1 || cap_first[1] !== 1'b0 || cap_first[9] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL first_win_first_flag: got w0=%b w1=%b w9=%b, want 1 0 1",
               cap_first[0], cap_first[1], cap_first[9]);
    end
    total++;
    if (cap_last[8] !== 1'b1 || cap_last[7] !== 1'b0 || cap_last[9] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL first_win_last_flag: got w7=%b w8=%b w9=%b, want 0 1 0",
               cap_last[7], cap_last[8], cap_last[9]);
    end
    total++;
    if (first_valid_cyc !== 2) begin
      bad++;
      $display("[TB] FAIL start_latency: got %0d cycles, want 2", first_valid_cyc);
    end
    pulse_reset();
  endtask

  task automatic test_full_frame();
    run_frame(1'b0, 1'b0, 0);
    total++;
    if (nwords !== 6084) begin bad++; $display("[TB] FAIL full_count: got %0d, want 6084", nwords); end
    total++;
    if (data_errs !== 0) begin
      bad++;
      $display("[TB] FAIL full_data: %0d wrong words, first at %0d, want none", data_errs, first_bad);
    end
    total++;
    if (flag_errs !== 0 || fl_count !== 1) begin
      bad++;
      $display("[TB] FAIL full_flags: got %0d flag errors and %0d frame_last, want 0 and 1", flag_errs, fl_count);
    end
    // address 783 reads back as 783 mod 256
    total++;
    if (last_data !== 8'd15) begin bad++; $display("[TB] FAIL full_last_data: got %0d, want 15", last_data); end
    total++;
    if (done_cnt !== 1 || done_cyc - last_acc_cyc !== 1) begin
      bad++;
      $display("[TB] FAIL full_done: got %0d pulses, gap %0d, want 1 pulse, gap 1", done_cnt, done_cyc - last_acc_cyc);
    end
    total++;
    if (busy_errs !== 0 || wr_errs !== 0) begin
      bad++;
      $display("[TB] FAIL full_busy_wr: got busy errs %0d, ram_wr errs %0d, want 0 and 0", busy_errs, wr_errs);
    end
  endtask

  task automatic test_random_ready();
    run_frame(1'b1, 1'b0, 0);
    total++;
    if (nwords !== 6084 || data_errs !== 0 || flag_errs !== 0) begin
      bad++;
      $display("[TB] FAIL rand_stream: got %0d words, %0d data errs, %0d flag errs, want 6084 0 0",
               nwords, data_errs, flag_errs);
    end
    total++;
    if (stall_errs !== 0 || stall_cycles == 0) begin
      bad++;
      $display("[TB] FAIL rand_stall: got %0d stall errs over %0d stalls, want 0 errs and some stalls",
               stall_errs, stall_cycles);
    end
    total++;
    if (done_cnt !== 1) begin bad++; $display("[TB] FAIL rand_done: got %0d pulses, want 1", done_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    run_frame(1'b0, 1'b0, 100);
    rst = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if ({win_valid_a, busy_a, ram_rd_a} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL mid_reset: got valid/busy/rd %b, want 000", {win_valid_a, busy_a, ram_rd_a});
    end
    rst = 1'b0;
    run_frame(1'b0, 1'b0, 3);
    total++;
    if (cap_data[0] !== 8'd0 || cap_data[1] !== 8'd1 || cap_first[0] !== 1'b1 || first_valid_cyc !== 2) begin
      bad++;
      $display("[TB] FAIL restart: got w0=%0d w1=%0d first=%b lat=%0d, want 0 1 1 2",
               cap_data[0], cap_data[1], cap_first[0], first_valid_cyc);
    end
    pulse_reset();
  endtask

  task automatic test_start_while_busy();
    run_frame(1'b0, 1'b1, 0);
    total++;
    if (nwords !== 6084 || data_errs !== 0) begin
      bad++;
      $display("[TB] FAIL busy_start_count: got %0d words, %0d data errs, want 6084 0", nwords, data_errs);
    end
    total++;
    if (done_cnt !== 1 || busy_errs !== 0) begin
      bad++;
      $display("[TB] FAIL busy_start_done: got %0d pulses, %0d busy errs, want 1 0", done_cnt, busy_errs);
    end
  endtask

  task automatic test_stride2();
    logic [7:0] bd [0:63];
    logic       bfirst [0:63];
    logic       bfl [0:63];
    int         n, cyc;
    bit         seen_done;
    n = 0; seen_done = 1'b0;
    @(negedge clk);
    start_b = 1'b1; win_ready_b = 1'b1;
    for (cyc = 0; cyc < 300 && !seen_done; cyc++) begin
      #1;
      if (win_valid_b && win_ready_b && n < 64) begin
        bd[n] = win_data_b; bfirst[n] = win_first_b; bfl[n] = frame_last_b;
        n++;
      end
      if (done_b) seen_done = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
    end
    total++;
    if (n !== 36 || !seen_done) begin
      bad++;
      $display("[TB] FAIL s2_count: got %0d words, done=%b, want 36 and 1", n, seen_done);
    end
    if (n >= 36) begin
      total++;
      if (bd[0] !== 8'd0 || bd[3] !== 8'd6 || bd[9] !== 8'd2) begin
        bad++;
        $display("[TB] FAIL s2_first_rows: got w0=%0d w3=%0d w9=%0d, want 0 6 2", bd[0], bd[3], bd[9]);
      end
      total++;
      if (bd[18] !== 8'd12 || bfirst[18] !== 1'b1) begin
        bad++;
        $display("[TB] FAIL s2_row2_start: got %0d first=%b, want 12 1", bd[18], bfirst[18]);
      end
      // stride-2 windows stop at row/column 4, so the final pixel is (4,4) = 28
      total++;
      if (bd[35] !== 8'd28 || bfl[35] !== 1'b1 || bfl[34] !== 1'b0) begin
        bad++;
        $display("[TB] FAIL s2_last: got %0d fl=%b prev_fl=%b, want 28 1 0", bd[35], bfl[35], bfl[34]);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 784; a++) mem_a[a] = 8'(a);
    for (int a = 0; a < 36; a++) mem_b[a] = 8'(a);
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; win_ready_a = 1'b1; win_ready_b = 1'b1;
    test_reset();
    test_first_window();
    test_full_frame();
    test_random_ready();
    test_reset_mid_frame();
    test_start_while_busy();
    test_stride2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
